// File: rtl/minisys_io_pkg.sv
// Shared definitions for the Minisys-1A IO-mapped system blocks:
// register offsets, reset-cause bit positions and reset-controller states.
package minisys_io_pkg;

  localparam logic [1:0] ADDR_CAUSE  = 2'd0;
  localparam logic [1:0] ADDR_WDTCNT = 2'd1;
  localparam logic [1:0] ADDR_SWRST  = 2'd2;

  localparam int CAUSE_EXT = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;

  localparam logic [15:0] SW_KEY_DEFAULT = 16'hA5A5;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

endpackage

// File: rtl/rst_stretch.sv
// Reset stretcher: holds o_cpuReset high for HOLD_CYCLES cycles after the
// last reset or trigger edge, then releases into RUN.
module rst_stretch
  import minisys_io_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_trigger,
  output logic o_cpuReset,
  output logic o_run
);

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  rst_state_e r_state;
  logic [7:0] r_holdCnt;
  logic       r_cpuReset;

  // A trigger while already holding simply reloads the counter, extending the pulse.
  always_ff @(posedge clock) begin
    if (reset || i_trigger) begin
      r_state    <= HOLD;
      r_holdCnt  <= RELOAD;
      r_cpuReset <= 1'b1;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_holdCnt == 8'd0) begin
            r_state    <= RUN;
            r_cpuReset <= 1'b0;
          end else begin
            r_holdCnt <= r_holdCnt - 8'd1;
          end
        end
        RUN: r_cpuReset <= 1'b0;
      endcase
    end
  end

  assign o_cpuReset = r_cpuReset;
  assign o_run      = (r_state == RUN);

endmodule

// File: rtl/rst_ctrl.sv
// System reset controller: merges external, watchdog and software resets into
// one stretched cpu_reset and keeps a sticky cause register plus WDT counter.
module rst_ctrl
  import minisys_io_pkg::*;
#(
  parameter int          HOLD_CYCLES = 16,
  parameter logic [15:0] SW_KEY      = SW_KEY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wdt_reset_in,
  input  logic        Select,
  input  logic        Write_enable,
  input  logic        Read_enable,
  input  logic [1:0]  Address,
  input  logic [15:0] Write_data_in,
  output logic [15:0] Read_data_out,
  output logic        cpu_reset
);

  logic        r_wdtPrev;
  logic [2:0]  r_cause;
  logic [7:0]  r_wdtCount;
  logic [15:0] r_readData;

  logic        w_run;
  logic        w_wdtEdge;
  logic        w_ioWrite;
  logic        w_swHit;
  logic        w_cntClear;
  logic [2:0]  w_causeNext;
  logic [15:0] w_readMux;

  assign w_wdtEdge  = wdt_reset_in && !r_wdtPrev;
  assign w_ioWrite  = Select && Write_enable && w_run;
  assign w_swHit    = w_ioWrite && (Address == ADDR_SWRST) && (Write_data_in == SW_KEY);
  assign w_cntClear = w_ioWrite && (Address == ADDR_WDTCNT);

  rst_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clock     (clock),
    .reset     (reset),
    .i_trigger (w_wdtEdge || w_swHit),
    .o_cpuReset(cpu_reset),
    .o_run     (w_run)
  );

  // Clear is applied before the sets so a same-cycle event always wins.
  always_comb begin
    w_causeNext = r_cause;
    if (w_ioWrite && (Address == ADDR_CAUSE)) begin
      w_causeNext = w_causeNext & ~Write_data_in[2:0];
    end
    if (w_wdtEdge) begin
      w_causeNext[CAUSE_WDT] = 1'b1;
    end
    if (w_swHit) begin
      w_causeNext[CAUSE_SW] = 1'b1;
    end
  end

  always_comb begin
    case (Address)
      ADDR_CAUSE:  w_readMux = {13'b0, r_cause};
      ADDR_WDTCNT: w_readMux = {8'b0, r_wdtCount};
      default:     w_readMux = 16'h0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wdtPrev  <= 1'b0;
      r_cause    <= 3'b001;
      r_wdtCount <= 8'h00;
      r_readData <= 16'h0000;
    end else begin
      r_wdtPrev <= wdt_reset_in;
      r_cause   <= w_causeNext;
      if (w_wdtEdge) begin
        if (w_cntClear) begin
          r_wdtCount <= 8'h01;
        end else if (r_wdtCount != 8'hFF) begin
          r_wdtCount <= r_wdtCount + 8'h01;
        end
      end else if (w_cntClear) begin
        r_wdtCount <= 8'h00;
      end
      if (Select && Read_enable) begin
        r_readData <= w_readMux;
      end
    end
  end

  assign Read_data_out = r_readData;

endmodule

// File: tb/tb_rst_ctrl.sv
// Self-checking bench for rst_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the controller.
module tb_rst_ctrl;

  localparam int          HOLD = 16;
  localparam logic [15:0] KEY  = 16'hA5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic        wdt_reset_in;
  logic        Select;
  logic        Write_enable;
  logic        Read_enable;
  logic [1:0]  Address;
  logic [15:0] Write_data_in;
  logic [15:0] Read_data_out;
  logic        cpu_reset;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: cycles of reset still owed, cause bits, event count, last read.
  int          mRemain = 0;
  logic [2:0]  mCause  = 3'b000;
  int          mCnt    = 0;
  logic        mPrev   = 1'b0;
  logic [15:0] mRd     = 16'h0000;

  rst_ctrl #(
    .HOLD_CYCLES(HOLD),
    .SW_KEY     (KEY)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wdt_reset_in (wdt_reset_in),
    .Select       (Select),
    .Write_enable (Write_enable),
    .Read_enable  (Read_enable),
    .Address      (Address),
    .Write_data_in(Write_data_in),
    .Read_data_out(Read_data_out),
    .cpu_reset    (cpu_reset)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelUpdate();
    logic        running;
    logic        wEdge;
    logic        wr;
    logic        sw;
    if (reset) begin
      mRemain = HOLD;
      mCause  = 3'b001;
      mCnt    = 0;
      mPrev   = 1'b0;
      mRd     = 16'h0000;
    end else begin
      running = (mRemain == 0);
      wEdge   = wdt_reset_in && !mPrev;
      wr      = Select && Write_enable && running;
      sw      = wr && (Address == 2'd2) && (Write_data_in == KEY);
      if (Select && Read_enable) begin
        if (Address == 2'd0)      mRd = {13'b0, mCause};
        else if (Address == 2'd1) mRd = 16'(mCnt);
        else                      mRd = 16'h0000;
      end
      if (wr && Address == 2'd0) mCause = mCause & ~Write_data_in[2:0];
      if (wEdge) mCause[1] = 1'b1;
      if (sw)    mCause[2] = 1'b1;
      if (wr && Address == 2'd1) mCnt = wEdge ? 1 : 0;
      else if (wEdge)            mCnt = (mCnt >= 255) ? 255 : mCnt + 1;
      if (wEdge || sw)       mRemain = HOLD;
      else if (mRemain > 0)  mRemain = mRemain - 1;
      mPrev = wdt_reset_in;
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    modelUpdate();
    #1;
    checkOutput("cpu_reset", cpu_reset, (mRemain > 0) ? 32'd1 : 32'd0);
    checkOutput("read_data", Read_data_out, mRd);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic rst, input logic wdt, input logic sel, input logic we,
                               input logic re, input logic [1:0] addr, input logic [15:0] data);
    reset         = rst;
    wdt_reset_in  = wdt;
    Select        = sel;
    Write_enable  = we;
    Read_enable   = re;
    Address       = addr;
    Write_data_in = data;
    stepCycle();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [15:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, addr, data);
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [15:0] value);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, addr, 16'h0000);
    value = Read_data_out;
  endtask

  // Counts high cycles of cpu_reset starting with the current one; wdt held high for wdtHigh steps.
  task automatic holdLen(input int wdtHigh, output int n);
    int i;
    n = 0;
    i = 0;
    while (cpu_reset === 1'b1 && n < 400) begin
      n++;
      applyStimulus(1'b0, (i < wdtHigh), 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      i++;
    end
  endtask

  initial begin
    logic [15:0] v;
    int          n;
    int          total;
    logic        wLevel;

    reset = 1'b1; wdt_reset_in = 1'b0; Select = 1'b0; Write_enable = 1'b0;
    Read_enable = 1'b0; Address = 2'd0; Write_data_in = 16'h0000;

    // Power-on
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    checkOutput("por_rdata", Read_data_out, 16'h0000);
    holdLen(0, n);
    checkOutput("por_hold", n, HOLD);
    readReg(2'd0, v); checkOutput("por_cause", v, 16'h0001);
    readReg(2'd1, v); checkOutput("por_wdtcnt", v, 16'h0000);
    writeReg(2'd0, 16'hFFFF);

    // Four-cycle WDT pulse counts once
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    holdLen(3, n);
    checkOutput("wdt_hold", n, HOLD);
    writeReg(2'd0, 16'h0000);
    writeReg(2'd0, 16'h0001);
    readReg(2'd0, v); checkOutput("wdt_cause", v, 16'h0002);
    writeReg(2'd0, 16'h0000);
    readReg(2'd1, v); checkOutput("wdt_cnt", v, 16'h0001);
    writeReg(2'd0, 16'h0003);
    readReg(2'd0, v); checkOutput("cause_clr", v, 16'h0000);

    // Software reset: wrong key, right key, simultaneous with WDT
    writeReg(2'd2, 16'h1234);
    idle();
    checkOutput("sw_badkey", cpu_reset, 1'b0);
    writeReg(2'd2, KEY);
    holdLen(0, n);
    checkOutput("sw_hold", n, HOLD);
    readReg(2'd0, v); checkOutput("sw_cause", v, 16'h0004);
    writeReg(2'd0, 16'h0007);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, KEY);
    holdLen(0, n);
    checkOutput("both_hold", n, HOLD);
    readReg(2'd0, v); checkOutput("both_cause", v, 16'h0006);
    readReg(2'd1, v); checkOutput("both_cnt", v, 16'h0002);
    writeReg(2'd0, 16'h0007);

    // WDT edge at hold cycle 10 extends; CAUSE write during hold ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    total = (cpu_reset === 1'b1) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) writeReg(2'd0, 16'h0007);
      else        idle();
      if (cpu_reset === 1'b1) total++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    holdLen(0, n);
    checkOutput("ext_hold", total + n, 10 + HOLD);
    readReg(2'd0, v); checkOutput("ext_cause", v, 16'h0002);
    readReg(2'd1, v); checkOutput("ext_cnt", v, 16'h0004);

    // Saturation, counter clear, external reset mid-hold
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      idle();
    end
    holdLen(0, n);
    readReg(2'd1, v); checkOutput("sat_cnt", v, 16'h00FF);
    writeReg(2'd1, 16'h5A5A);
    readReg(2'd1, v); checkOutput("cnt_clr", v, 16'h0000);
    writeReg(2'd2, KEY);
    for (int i = 0; i < 6; i++) idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    holdLen(0, n);
    checkOutput("rst_hold", n, HOLD);
    readReg(2'd0, v); checkOutput("rst_cause", v, 16'h0001);
    readReg(2'd1, v); checkOutput("rst_cnt", v, 16'h0000);

    // Read latency and hold of read data
    readReg(2'd0, v); checkOutput("rd_latency", v, 16'h0001);
    writeReg(2'd0, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("rd_held", Read_data_out, 16'h0001);
    end
    readReg(2'd3, v); checkOutput("rd_reserved", v, 16'h0000);

    // Randomized traffic against the model
    wLevel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) wLevel = ~wLevel;
      applyStimulus(($urandom_range(0, 299) == 0), wLevel, ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
